pe_result_drain: RTL and testbench

Output-side companion of the 2×16 PE array. It captures the array's full result tile (2 rows × 16 columns × 16 bit) on every `rounder_valid` pulse, together with its `round_number` tag, into a small tile FIFO. It then streams each tile out one 256-bit row per beat over a valid/ready interface toward the output buffer. It raises `stall` so the operand sequencer can hold the array (via `keep`) before tiles are lost.

---
 rtl/pe_drain_pkg.sv | 27 ++
 rtl/pe_result_drain_if.sv | 48 ++++
 rtl/pe_drain_fifo.sv | 72 +++++++
 rtl/pe_result_drain.sv | 151 +++++++++++++++
 tb/tb_pe_result_drain.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pe_drain_pkg.sv
// -----------------------------------------------------------------------------
// pe_drain_pkg
// Shared constants and types for the PE result drain.
//   PE_ROWS/PE_COLS/PE_DW/PE_TAG_W : default tile geometry (2 x 16 x 16 bit, 4-bit tag)
//   tile_t                         : one captured result tile plus its round tag
//   drain_state_e                  : tile FSM states of the drain
// tile_t is sized from these constants, so the drain's geometry parameters
// are expected to stay at the package defaults.
// -----------------------------------------------------------------------------
package pe_drain_pkg;

  localparam int PE_ROWS  = 2;
  localparam int PE_COLS  = 16;
  localparam int PE_DW    = 16;
  localparam int PE_TAG_W = 4;

  typedef struct packed {
    logic [PE_ROWS-1:0][PE_COLS-1:0][PE_DW-1:0] data;
    logic [PE_TAG_W-1:0]                        tag;
  } tile_t;

  typedef enum logic [0:0] {
    ST_EMPTY  = 1'b0,
    ST_STREAM = 1'b1
  } drain_state_e;

endpackage

// File: rtl/pe_result_drain_if.sv
// -----------------------------------------------------------------------------
// pe_result_drain_if
// Row-beat stream from the result drain toward the output buffer.
//   out_valid : beat valid (master -> slave)
//   out_ready : beat accepted (slave -> master)
//   out_data  : one PE row, column n at bits [n*DW +: DW]
//   out_row   : row index of the beat
//   out_tag   : round tag of the tile being streamed
//   out_last  : final row of the tile
// Modports: master (drain side), slave (output-buffer side).
// -----------------------------------------------------------------------------
interface pe_result_drain_if
  import pe_drain_pkg::*;
#(
  parameter int ROWS  = PE_ROWS,
  parameter int COLS  = PE_COLS,
  parameter int DW    = PE_DW,
  parameter int TAG_W = PE_TAG_W
);

  localparam int ROW_W = $clog2(ROWS);

  logic                 out_valid;
  logic                 out_ready;
  logic [COLS*DW-1:0]   out_data;
  logic [ROW_W-1:0]     out_row;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_tag,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_tag,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/pe_drain_fifo.sv
// -----------------------------------------------------------------------------
// pe_drain_fifo
// DEPTH-entry tile FIFO (DEPTH a power of two, >= 2).
//   clk, rst : clock, synchronous active-high reset (pointers and level only)
//   push     : write wr_tile at the tail (caller guarantees room)
//   pop      : free the head entry (caller guarantees non-empty)
//   wr_tile  : tile to write
//   head     : tile at the head pointer
//   level    : number of stored tiles
//   full     : level == DEPTH
// Push and pop in the same cycle leave level unchanged, which also holds when
// the FIFO is full: the head slot is read before the tail overwrites it.
// -----------------------------------------------------------------------------
module pe_drain_fifo
  import pe_drain_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  tile_t            wr_tile,
  output tile_t            head,
  output logic [LVL_W-1:0] level,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  tile_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Tile storage carries no reset; validity is tracked by level alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_tile;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_W'(DEPTH));

endmodule

// File: rtl/pe_result_drain.sv
// -----------------------------------------------------------------------------
// pe_result_drain
// Captures each result tile of the 2x16 PE array (with its round tag) into a
// tile FIFO and streams it out one 256-bit row per beat.
//   clk, rst      : clock, synchronous active-high reset
//   pe_array_out  : result tile from the PE array
//   rounder_valid : single-cycle pulse, tile valid
//   round_number  : tag of the tile
//   ob            : row-beat stream (master modport of pe_result_drain_if)
//   level         : tiles stored, including the one being streamed
//   stall         : level >= DEPTH-1, lets the sequencer hold the array
//   overflow      : sticky, a tile was dropped for lack of room
//   drop_cnt      : saturating count of dropped tiles (only with macro below)
// Optional feature macro: PE_DRAIN_DROP_CNT_EN adds the drop_cnt output.
// Result data is passed through untouched.
// -----------------------------------------------------------------------------
module pe_result_drain
  import pe_drain_pkg::*;
#(
  parameter  int ROWS  = PE_ROWS,
  parameter  int COLS  = PE_COLS,
  parameter  int DW    = PE_DW,
  parameter  int TAG_W = PE_TAG_W,
  parameter  int DEPTH = 4,
  localparam int ROW_W = $clog2(ROWS),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ROWS-1:0][COLS-1:0][DW-1:0]  pe_array_out,
  input  logic                               rounder_valid,
  input  logic [TAG_W-1:0]                   round_number,
  pe_result_drain_if.master                  ob,
  output logic [LVL_W-1:0]                   level,
  output logic                               stall,
  output logic                               overflow
`ifdef PE_DRAIN_DROP_CNT_EN
  ,
  output logic [15:0]                        drop_cnt
`endif
);

  tile_t            wr_tile;
  tile_t            head;
  logic             full;

  drain_state_e     state_q, state_d;
  logic [ROW_W-1:0] beat_q, beat_d;
  logic             overflow_q, overflow_d;

  logic             valid;
  logic             last_beat;
  logic             xfer;
  logic             pop;
  logic             room;
  logic             push;
  logic             drop;

  assign wr_tile.data = pe_array_out;
  assign wr_tile.tag  = round_number;

  pe_drain_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_tile (wr_tile),
    .head    (head),
    .level   (level),
    .full    (full)
  );

  // A full FIFO still accepts a tile when the head's final beat leaves in
  // the same cycle.
  always_comb begin
    valid     = (state_q == ST_STREAM);
    last_beat = (beat_q == ROW_W'(ROWS - 1));
    xfer      = valid && ob.out_ready;
    pop       = xfer && last_beat;
    room      = !full || pop;
    push      = rounder_valid && room;
    drop      = rounder_valid && !room;
  end

  // Tile FSM and row serializer.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    overflow_d = overflow_q | drop;
    if (xfer) beat_d = last_beat ? '0 : beat_q + 1'b1;
    case (state_q)
      ST_EMPTY:  if (push) state_d = ST_STREAM;
      ST_STREAM: if (pop && (level == LVL_W'(1)) && !push) state_d = ST_EMPTY;
      default:   state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  // Beat outputs are gated to zero while idle so no stale tile is visible.
  always_comb begin
    ob.out_valid = valid;
    ob.out_data  = '0;
    ob.out_row   = '0;
    ob.out_tag   = '0;
    ob.out_last  = 1'b0;
    if (valid) begin
      ob.out_data = head.data[beat_q];
      ob.out_row  = beat_q;
      ob.out_tag  = head.tag;
      ob.out_last = last_beat;
    end
  end

  assign stall    = (level >= LVL_W'(DEPTH - 1));
  assign overflow = overflow_q;

`ifdef PE_DRAIN_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) drop_cnt_d = sat_inc16(drop_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pe_result_drain.sv
module tb_pe_result_drain;
  import pe_drain_pkg::*;

  typedef logic [PE_ROWS-1:0][PE_COLS-1:0][PE_DW-1:0] tile_data_t;

  typedef struct {
    logic        rv;
    logic [3:0]  tag;
    logic [15:0] base;
    logic        rdy;
    logic        ev;
    logic        erow;
    logic [3:0]  etag;
    logic        elast;
    logic [15:0] ebase;
    logic [2:0]  elvl;
    logic        estall;
    logic        eovf;
  } vec_t;

  logic        clk;
  logic        rst;
  tile_data_t  pe_array_out;
  logic        rounder_valid;
  logic [3:0]  round_number;
  logic [2:0]  level;
  logic        stall;
  logic        overflow;
`ifdef PE_DRAIN_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_cmp;
  int n_err;
  vec_t tbl[$];

  pe_result_drain_if ob ();

  pe_result_drain dut (
    .clk           (clk),
    .rst           (rst),
    .pe_array_out  (pe_array_out),
    .rounder_valid (rounder_valid),
    .round_number  (round_number),
    .ob            (ob),
    .level         (level),
    .stall         (stall),
    .overflow      (overflow)
`ifdef PE_DRAIN_DROP_CNT_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tile whose PE n (n = row*16 + col) holds base + n.
  function automatic tile_data_t build_tile(input logic [15:0] base);
    tile_data_t t;
    for (int r = 0; r < PE_ROWS; r++)
      for (int c = 0; c < PE_COLS; c++)
        t[r][c] = base + 16'(r * PE_COLS + c);
    return t;
  endfunction

  function automatic logic [255:0] row_of(input logic [15:0] base, input int r);
    logic [255:0] v;
    for (int c = 0; c < PE_COLS; c++)
      v[c*16 +: 16] = base + 16'(r * PE_COLS + c);
    return v;
  endfunction

  function automatic vec_t mk(input logic rv, input logic [3:0] tag, input logic [15:0] base,
                              input logic rdy, input logic ev, input logic erow,
                              input logic [3:0] etag, input logic elast, input logic [15:0] ebase,
                              input logic [2:0] elvl, input logic estall, input logic eovf);
    vec_t v;
    v.rv = rv; v.tag = tag; v.base = base; v.rdy = rdy;
    v.ev = ev; v.erow = erow; v.etag = etag; v.elast = elast; v.ebase = ebase;
    v.elvl = elvl; v.estall = estall; v.eovf = eovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic ev, input logic erow, input logic [3:0] etag,
                           input logic elast, input logic [15:0] ebase, input logic [2:0] elvl,
                           input logic estall, input logic eovf);
    chk({nm, " out_valid"}, 256'(ob.out_valid), 256'(ev));
    chk({nm, " out_row"},   256'(ob.out_row),   256'(ev ? erow : 1'b0));
    chk({nm, " out_tag"},   256'(ob.out_tag),   256'(ev ? etag : 4'd0));
    chk({nm, " out_last"},  256'(ob.out_last),  256'(ev ? elast : 1'b0));
    chk({nm, " out_data"},  ob.out_data,        ev ? row_of(ebase, int'(erow)) : 256'd0);
    chk({nm, " level"},     256'(level),        256'(elvl));
    chk({nm, " stall"},     256'(stall),        256'(estall));
    chk({nm, " overflow"},  256'(overflow),     256'(eovf));
  endtask

  task automatic drive(input logic rv, input logic [3:0] tag, input logic [15:0] base, input logic rdy);
    rounder_valid = rv;
    round_number  = tag;
    pe_array_out  = build_tile(base);
    ob.out_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    //          rv  tag    base      rdy  ev  row tag   last ebase     lvl  st  ovf
    // single tile, no backpressure
    tbl.push_back(mk(1, 4'd5, 16'h0100, 1,  0, 0, 4'd0, 0, 16'h0000, 3'd0, 0, 0));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  1, 0, 4'd5, 0, 16'h0100, 3'd1, 0, 0));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  1, 1, 4'd5, 1, 16'h0100, 3'd1, 0, 0));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  0, 0, 4'd0, 0, 16'h0000, 3'd0, 0, 0));
    // backpressure for 5 cycles, then two consecutive beats
    tbl.push_back(mk(1, 4'd6, 16'h6000, 0,  0, 0, 4'd0, 0, 16'h0000, 3'd0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 4'd0, 16'h0000, 0,  1, 0, 4'd6, 0, 16'h6000, 3'd1, 0, 0));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  1, 0, 4'd6, 0, 16'h6000, 3'd1, 0, 0));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  1, 1, 4'd6, 1, 16'h6000, 3'd1, 0, 0));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 0,  0, 0, 4'd0, 0, 16'h0000, 3'd0, 0, 0));
    // fill with tags 0..3 while stalled downstream
    tbl.push_back(mk(1, 4'd0, 16'h0800, 0,  0, 0, 4'd0, 0, 16'h0000, 3'd0, 0, 0));
    tbl.push_back(mk(1, 4'd1, 16'h1800, 0,  1, 0, 4'd0, 0, 16'h0800, 3'd1, 0, 0));
    tbl.push_back(mk(1, 4'd2, 16'h2800, 0,  1, 0, 4'd0, 0, 16'h0800, 3'd2, 0, 0));
    tbl.push_back(mk(1, 4'd3, 16'h3800, 0,  1, 0, 4'd0, 0, 16'h0800, 3'd3, 1, 0));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  1, 0, 4'd0, 0, 16'h0800, 3'd4, 1, 0));
    // full, last beat of head leaves while tag 9 arrives
    tbl.push_back(mk(1, 4'd9, 16'h9800, 1,  1, 1, 4'd0, 1, 16'h0800, 3'd4, 1, 0));
    // full, no free: tag 7 dropped
    tbl.push_back(mk(1, 4'd7, 16'h7800, 0,  1, 0, 4'd1, 0, 16'h1800, 3'd4, 1, 0));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  1, 0, 4'd1, 0, 16'h1800, 3'd4, 1, 1));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  1, 1, 4'd1, 1, 16'h1800, 3'd4, 1, 1));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  1, 0, 4'd2, 0, 16'h2800, 3'd3, 1, 1));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  1, 1, 4'd2, 1, 16'h2800, 3'd3, 1, 1));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  1, 0, 4'd3, 0, 16'h3800, 3'd2, 0, 1));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  1, 1, 4'd3, 1, 16'h3800, 3'd2, 0, 1));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  1, 0, 4'd9, 0, 16'h9800, 3'd1, 0, 1));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  1, 1, 4'd9, 1, 16'h9800, 3'd1, 0, 1));
    tbl.push_back(mk(0, 4'd0, 16'h0000, 1,  0, 0, 4'd0, 0, 16'h0000, 3'd0, 0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].rv, tbl[i].tag, tbl[i].base, tbl[i].rdy);
      #1;
      check_all($sformatf("step%0d", i), tbl[i].ev, tbl[i].erow, tbl[i].etag, tbl[i].elast,
                tbl[i].ebase, tbl[i].elvl, tbl[i].estall, tbl[i].eovf);
      tick();
    end

    // Reset clears the sticky overflow and every output.
    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0000, 1'b0);
    tick();
    rst = 1'b0;
    check_all("after_rst", 0, 0, 4'd0, 0, 16'h0000, 3'd0, 0, 0);

    // Reset mid-stream with a 3-tile backlog.
    drive(1'b1, 4'd1, 16'h1A00, 1'b0); tick();
    drive(1'b1, 4'd2, 16'h2A00, 1'b0); tick();
    drive(1'b1, 4'd3, 16'h3A00, 1'b0); tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b1); tick();
    check_all("pre_rst", 1, 1, 4'd1, 1, 16'h1A00, 3'd3, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("mid_rst", 0, 0, 4'd0, 0, 16'h0000, 3'd0, 0, 0);
    tick();
    tick();
    check_all("post_rst_idle", 0, 0, 4'd0, 0, 16'h0000, 3'd0, 0, 0);
    drive(1'b1, 4'd12, 16'hC000, 1'b1); tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b1);
    check_all("post_rst_cap0", 1, 0, 4'd12, 0, 16'hC000, 3'd1, 0, 0);
    tick();
    check_all("post_rst_cap1", 1, 1, 4'd12, 1, 16'hC000, 3'd1, 0, 0);
    tick();
    check_all("post_rst_done", 0, 0, 4'd0, 0, 16'h0000, 3'd0, 0, 0);

`ifdef PE_DRAIN_DROP_CNT_EN
    chk("drop_cnt_zero", 256'(drop_cnt), 256'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'(k), 16'h0400, 1'b0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'd15, 16'hF000, 1'b0);
      tick();
    end
    drive(1'b0, 4'd0, 16'h0000, 1'b0);
    chk("drop_cnt_three", 256'(drop_cnt), 256'd3);
    chk("drop_ovf", 256'(overflow), 256'd1);
    force dut.drop_cnt_q = 16'hFFFF;
    #1;
    release dut.drop_cnt_q;
    drive(1'b1, 4'd15, 16'hF000, 1'b0);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0);
    chk("drop_cnt_sat", 256'(drop_cnt), 256'hFFFF);
    chk("drop_level", 256'(level), 256'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
